multicycle_control_unit: RTL

Parametrised multi-cycle controller for the 16-bit-instruction CPU core, the successor to the fixed-width control unit. It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives register file, ALU, immediate mux and data-memory controls. Unlike its predecessor, it:
- handshakes with program memory and data memory, stalling on wait states;
- executes jumps and conditional branches on ALU flags;
- supports HALT and flags illegal opcodes.

It sits between program memory, the register file/ALU datapath and the data-memory port.

---
 rtl/cu_pkg.sv | 57 +++++
 rtl/instr_decoder.sv | 57 +++++
 rtl/multicycle_control_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the multi-cycle control unit.
//   - opcode_e       : non-ALU opcodes of the 16-bit instruction set
//   - cu_state_e     : controller states
//   - instr_class_e  : decoded instruction class used by the FSM
//   - field bit positions within the instruction register
//   - is_alu_op()    : ALU-class test (opcode MSB set)
package cu_pkg;

    localparam int INSTR_WIDTH = 16;

    // Instruction field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 5;
    localparam int RT_MSB  = 4;
    localparam int RT_LSB  = 2;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [4:0] {
        OP_NOP  = 5'b00000,
        OP_LD   = 5'b00001,
        OP_ST   = 5'b00010,
        OP_JMP  = 5'b00011,
        OP_BZ   = 5'b00100,
        OP_BP   = 5'b00101,
        OP_HALT = 5'b00110
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALTED    = 3'd5
    } cu_state_e;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_JMP  = 3'd4,
        CLS_BZ   = 3'd5,
        CLS_BP   = 3'd6,
        CLS_HALT = 3'd7
    } instr_class_e;

    function automatic logic is_alu_op(input logic [4:0] opcode);
        return opcode[4];
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational decode of the instruction register.
// Ports:
//   ir          in  16  instruction register
//   rd/rs/rt    out 3   register address fields
//   imm8        out 8   raw immediate field
//   alu_sel     out 4   opcode[4:1] for ALU class, 0 otherwise
//   imm_sel     out 1   ~opcode[0] for ALU class, 0 otherwise
//   instr_class out     class consumed by the FSM
//   illegal     out 1   opcode is undefined (class reported as NOP)
module instr_decoder
    import cu_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] ir,
    output logic [2:0]             rd_addr,
    output logic [2:0]             rs_addr,
    output logic [2:0]             rt_addr,
    output logic [7:0]             imm8,
    output logic [3:0]             alu_sel,
    output logic                   imm_sel,
    output instr_class_e           instr_class,
    output logic                   illegal
);

    logic [4:0] opcode;

    assign opcode  = ir[OPC_MSB:OPC_LSB];
    assign rd_addr = ir[RD_MSB:RD_LSB];
    assign rs_addr = ir[RS_MSB:RS_LSB];
    assign rt_addr = ir[RT_MSB:RT_LSB];
    assign imm8    = ir[IMM_MSB:IMM_LSB];

    always_comb begin
        alu_sel     = 4'd0;
        imm_sel     = 1'b0;
        illegal     = 1'b0;
        instr_class = CLS_NOP;
        if (is_alu_op(opcode)) begin
            instr_class = CLS_ALU;
            alu_sel     = opcode[4:1];
            // Even ALU opcodes take the immediate as operand B.
            imm_sel     = ~opcode[0];
        end else begin
            case (opcode)
                OP_NOP:  instr_class = CLS_NOP;
                OP_LD:   instr_class = CLS_LD;
                OP_ST:   instr_class = CLS_ST;
                OP_JMP:  instr_class = CLS_JMP;
                OP_BZ:   instr_class = CLS_BZ;
                OP_BP:   instr_class = CLS_BP;
                OP_HALT: instr_class = CLS_HALT;
                // 00111..01111: flagged, then behaves as NOP.
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for
// the 16-bit-instruction core. Holds PC, IR and the sticky illegal flag.
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   pm_data/pm_valid/pm_req program-memory fetch handshake
//   PC                      current instruction address
//   zero_flag/pos_flag      ALU flags, sampled in EXECUTE
//   mem_ready/mem_req/mem_write/mem_sel  data-memory handshake and mux
//   rf_write, rs/rt/rd_addr register-file controls
//   imm_data/alu_sel/imm_sel ALU operand and operation controls
//   halted, illegal_op      status
//   dbg_state               current FSM state, for observation only
//
// Handshakes: a request (pm_req in FETCH, mem_req in MEM) stays asserted
// every cycle until the matching completion (pm_valid, mem_ready) is seen
// high on a rising edge; completions seen in any other state are ignored.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int                  DATA_WIDTH = 16,
    parameter int                  PC_WIDTH   = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INSTR_WIDTH-1:0] pm_data,
    input  logic                   pm_valid,
    output logic                   pm_req,
    output logic [PC_WIDTH-1:0]    PC,
    input  logic                   zero_flag,
    input  logic                   pos_flag,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   mem_write,
    output logic                   mem_sel,
    output logic                   rf_write,
    output logic [2:0]             rs_addr,
    output logic [2:0]             rt_addr,
    output logic [2:0]             rd_addr,
    output logic [DATA_WIDTH-1:0]  imm_data,
    output logic [3:0]             alu_sel,
    output logic                   imm_sel,
    output logic                   halted,
    output logic                   illegal_op,
    output cu_state_e              dbg_state
);

    cu_state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]     ir_q, ir_d;
    logic                       illegal_q, illegal_d;

    logic [7:0]                 dec_imm8;
    instr_class_e               dec_class;
    logic                       dec_illegal;
    logic [PC_WIDTH-1:0]        branch_target;

    instr_decoder u_decoder (
        .ir          (ir_q),
        .rd_addr     (rd_addr),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .imm8        (dec_imm8),
        .alu_sel     (alu_sel),
        .imm_sel     (imm_sel),
        .instr_class (dec_class),
        .illegal     (dec_illegal)
    );

    // imm8 is truncated or zero-extended to the PC width.
    assign branch_target = PC_WIDTH'(dec_imm8);
    assign imm_data      = DATA_WIDTH'(dec_imm8);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state, PC and IR update
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH: begin
                if (pm_valid) begin
                    ir_d    = pm_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Wraps naturally at 2^PC_WIDTH.
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = EXECUTE;
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                end
            end
            EXECUTE: begin
                case (dec_class)
                    CLS_ALU:  state_d = WRITEBACK;
                    CLS_LD,
                    CLS_ST:   state_d = MEM;
                    CLS_JMP: begin
                        pc_d    = branch_target;
                        state_d = FETCH;
                    end
                    CLS_BZ: begin
                        if (zero_flag) begin
                            pc_d = branch_target;
                        end
                        state_d = FETCH;
                    end
                    CLS_BP: begin
                        if (pos_flag) begin
                            pc_d = branch_target;
                        end
                        state_d = FETCH;
                    end
                    CLS_HALT: state_d = HALTED;
                    default:  state_d = FETCH;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    state_d = (dec_class == CLS_LD) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: state_d = FETCH;
            HALTED:    state_d = HALTED;
            default:   state_d = FETCH;
        endcase
    end

    // Moore outputs
    always_comb begin
        pm_req    = (state_q == FETCH);
        mem_req   = (state_q == MEM);
        mem_write = (state_q == MEM) && (dec_class == CLS_ST);
        rf_write  = (state_q == WRITEBACK);
        mem_sel   = (state_q == WRITEBACK) && (dec_class == CLS_LD);
        halted    = (state_q == HALTED);
    end

    assign PC         = pc_q;
    assign illegal_op = illegal_q;
    assign dbg_state  = state_q;

endmodule
